// File: rtl/generic_bus_arbiter.sv
// Round-robin arbiter sharing one GenericBus subordinate port among NumMgrs managers.
// The grant is held for a whole transfer (every beat of a burst) before re-arbitrating.
module generic_bus_arbiter #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int ProtWidth = 4,
  parameter int NumMgrs   = 4,
  localparam int StrbWidth = DataWidth / 8,
  localparam int IdxW      = $clog2(NumMgrs)
) (
  input  logic                           clk,
  input  logic                           nReset,

  input  logic [NumMgrs-1:0]             mgr_wEn,
  input  logic [NumMgrs-1:0]             mgr_rEn,
  input  logic [NumMgrs*AddrWidth-1:0]   mgr_addr,
  input  logic [NumMgrs*DataWidth-1:0]   mgr_wData,
  input  logic [NumMgrs*StrbWidth-1:0]   mgr_wStrb,
  input  logic [NumMgrs-1:0]             mgr_isBurst,
  input  logic [NumMgrs*2-1:0]           mgr_burstType,
  input  logic [NumMgrs*8-1:0]           mgr_burstLen,
  input  logic [NumMgrs-1:0]             mgr_nonSec,
  input  logic [NumMgrs*ProtWidth-1:0]   mgr_prot,
  output logic [NumMgrs*DataWidth-1:0]   mgr_rData,
  output logic [NumMgrs-1:0]             mgr_error,
  output logic [NumMgrs-1:0]             mgr_busy,

  output logic                           bus_wEn,
  output logic                           bus_rEn,
  output logic [AddrWidth-1:0]           bus_addr,
  output logic [DataWidth-1:0]           bus_wData,
  output logic [StrbWidth-1:0]           bus_wStrb,
  output logic                           bus_isBurst,
  output logic [1:0]                     bus_burstType,
  output logic [7:0]                     bus_burstLen,
  output logic                           bus_nonSec,
  output logic [ProtWidth-1:0]           bus_prot,
  input  logic [DataWidth-1:0]           bus_rData,
  input  logic                           bus_error,
  input  logic                           bus_busy,

  output logic [NumMgrs-1:0]             grant
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  localparam logic [NumMgrs-1:0] GrantLsb  = NumMgrs'(1);
  localparam logic [IdxW-1:0]    LastInit  = IdxW'(NumMgrs - 1);

  state_t              state_q;
  logic [NumMgrs-1:0]  grant_q;
  logic [IdxW-1:0]     owner_q;
  logic [IdxW-1:0]     last_q;
  logic [7:0]          beats_q;

  logic [NumMgrs-1:0]  req;
  logic                win_found;
  logic [IdxW-1:0]     win_idx;
  logic                beat_done;
  logic                final_beat;
  logic                release_own;

  // Per-manager views of the packed input vectors, indexed by owner.
  logic [AddrWidth-1:0] addr_a   [NumMgrs];
  logic [DataWidth-1:0] wdata_a  [NumMgrs];
  logic [StrbWidth-1:0] wstrb_a  [NumMgrs];
  logic [1:0]           btype_a  [NumMgrs];
  logic [7:0]           blen_a   [NumMgrs];
  logic [ProtWidth-1:0] prot_a   [NumMgrs];

  for (genvar g = 0; g < NumMgrs; g++) begin : g_mgr
    assign addr_a[g]  = mgr_addr[g*AddrWidth +: AddrWidth];
    assign wdata_a[g] = mgr_wData[g*DataWidth +: DataWidth];
    assign wstrb_a[g] = mgr_wStrb[g*StrbWidth +: StrbWidth];
    assign btype_a[g] = mgr_burstType[g*2 +: 2];
    assign blen_a[g]  = mgr_burstLen[g*8 +: 8];
    assign prot_a[g]  = mgr_prot[g*ProtWidth +: ProtWidth];

    // Only the current owner sees the subordinate's response; everyone else stalls.
    assign mgr_rData[g*DataWidth +: DataWidth] = grant_q[g] ? bus_rData : '0;
    assign mgr_error[g] = grant_q[g] & bus_error;
    assign mgr_busy[g]  = grant_q[g] ? bus_busy : 1'b1;
  end

  assign req   = mgr_wEn | mgr_rEn;
  assign grant = grant_q;

  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int offset);
    return IdxW'((int'(base) + offset) % NumMgrs);
  endfunction

  // Scan last+1, last+2, ... so the previous owner is considered last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NumMgrs; k++) begin
      if (!win_found && req[rr_idx(last_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(last_q, k);
      end
    end
  end

  always_comb begin
    bus_wEn       = 1'b0;
    bus_rEn       = 1'b0;
    bus_addr      = '0;
    bus_wData     = '0;
    bus_wStrb     = '0;
    bus_isBurst   = 1'b0;
    bus_burstType = '0;
    bus_burstLen  = '0;
    bus_nonSec    = 1'b0;
    bus_prot      = '0;
    if (state_q == S_OWN) begin
      bus_wEn       = mgr_wEn[owner_q];
      bus_rEn       = mgr_rEn[owner_q];
      bus_addr      = addr_a[owner_q];
      bus_wData     = wdata_a[owner_q];
      bus_wStrb     = wstrb_a[owner_q];
      bus_isBurst   = mgr_isBurst[owner_q];
      bus_burstType = btype_a[owner_q];
      bus_burstLen  = blen_a[owner_q];
      bus_nonSec    = mgr_nonSec[owner_q];
      bus_prot      = prot_a[owner_q];
    end
  end

  assign beat_done  = (bus_wEn | bus_rEn) & ~bus_busy;
  // An error terminates a burst early, same as its natural final beat.
  assign final_beat = beat_done & (~bus_isBurst | (beats_q == bus_burstLen) | bus_error);
  assign release_own = final_beat | ~req[owner_q];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LastInit;
      beats_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q <= S_OWN;
            grant_q <= GrantLsb << win_idx;
            owner_q <= win_idx;
            beats_q <= '0;
          end
        end
        S_OWN: begin
          if (release_own) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= owner_q;
          end else if (beat_done && bus_isBurst) begin
            beats_q <= beats_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Directed bench for generic_bus_arbiter: reset, single read, round-robin, burst hold,
// error abort and asynchronous reset, each against hand-computed expectations.
module tb_generic_bus_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int PW = 4;
  localparam int NM = 4;
  localparam int SW = DW / 8;

  logic              clk;
  logic              nReset;
  logic [NM-1:0]     mgr_wEn;
  logic [NM-1:0]     mgr_rEn;
  logic [NM*AW-1:0]  mgr_addr;
  logic [NM*DW-1:0]  mgr_wData;
  logic [NM*SW-1:0]  mgr_wStrb;
  logic [NM-1:0]     mgr_isBurst;
  logic [NM*2-1:0]   mgr_burstType;
  logic [NM*8-1:0]   mgr_burstLen;
  logic [NM-1:0]     mgr_nonSec;
  logic [NM*PW-1:0]  mgr_prot;
  logic [NM*DW-1:0]  mgr_rData;
  logic [NM-1:0]     mgr_error;
  logic [NM-1:0]     mgr_busy;
  logic              bus_wEn;
  logic              bus_rEn;
  logic [AW-1:0]     bus_addr;
  logic [DW-1:0]     bus_wData;
  logic [SW-1:0]     bus_wStrb;
  logic              bus_isBurst;
  logic [1:0]        bus_burstType;
  logic [7:0]        bus_burstLen;
  logic              bus_nonSec;
  logic [PW-1:0]     bus_prot;
  logic [DW-1:0]     bus_rData;
  logic              bus_error;
  logic              bus_busy;
  logic [NM-1:0]     grant;

  int vectors;
  int miscompares;

  generic_bus_arbiter #(
    .DataWidth(DW), .AddrWidth(AW), .ProtWidth(PW), .NumMgrs(NM)
  ) dut (
    .clk(clk), .nReset(nReset),
    .mgr_wEn(mgr_wEn), .mgr_rEn(mgr_rEn), .mgr_addr(mgr_addr), .mgr_wData(mgr_wData),
    .mgr_wStrb(mgr_wStrb), .mgr_isBurst(mgr_isBurst), .mgr_burstType(mgr_burstType),
    .mgr_burstLen(mgr_burstLen), .mgr_nonSec(mgr_nonSec), .mgr_prot(mgr_prot),
    .mgr_rData(mgr_rData), .mgr_error(mgr_error), .mgr_busy(mgr_busy),
    .bus_wEn(bus_wEn), .bus_rEn(bus_rEn), .bus_addr(bus_addr), .bus_wData(bus_wData),
    .bus_wStrb(bus_wStrb), .bus_isBurst(bus_isBurst), .bus_burstType(bus_burstType),
    .bus_burstLen(bus_burstLen), .bus_nonSec(bus_nonSec), .bus_prot(bus_prot),
    .bus_rData(bus_rData), .bus_error(bus_error), .bus_busy(bus_busy),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_mgr(input int i, input logic wen, input logic ren,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic burst, input logic [7:0] len);
    mgr_wEn[i]                = wen;
    mgr_rEn[i]                = ren;
    mgr_addr[i*AW +: AW]      = addr;
    mgr_wData[i*DW +: DW]     = data;
    mgr_wStrb[i*SW +: SW]     = wen ? 4'hF : 4'h0;
    mgr_isBurst[i]            = burst;
    mgr_burstType[i*2 +: 2]   = burst ? 2'b01 : 2'b00;
    mgr_burstLen[i*8 +: 8]    = len;
    mgr_nonSec[i]             = 1'b0;
    mgr_prot[i*PW +: PW]      = 4'h2;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NM; i++) set_mgr(i, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nReset      = 1'b0;
    bus_rData   = '0;
    bus_error   = 1'b0;
    bus_busy    = 1'b0;
    clear_all();

    // Reset held with every manager reading.
    for (int i = 0; i < NM; i++) set_mgr(i, 1'b0, 1'b1, 32'h1000 + i*16, 32'h0, 1'b0, 8'h0);
    #12;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_busy", 32'(mgr_busy), 32'hF);
    check("reset_bus_ren", 32'(bus_rEn), 32'h0);
    check("reset_bus_addr", bus_addr, 32'h0);
    check("reset_rdata", 32'(|mgr_rData), 32'h0);
    check("reset_error", 32'(mgr_error), 32'h0);
    tick();
    nReset = 1'b1;
    tick();
    sample();
    check("first_grant", 32'(grant), 32'h1);
    check("first_busy", 32'(mgr_busy), 32'hE);
    check("first_bus_addr", bus_addr, 32'h1000);
    tick();
    clear_all();
    sample();
    check("first_release", 32'(grant), 32'h0);
    check("first_release_busy", 32'(mgr_busy), 32'hF);
    check("idle_bus_ren", 32'(bus_rEn), 32'h0);

    // Single read from manager 2 with zero wait states.
    tick();
    set_mgr(2, 1'b0, 1'b1, 32'h104, 32'h0, 1'b0, 8'h0);
    bus_rData = 32'hDEADBEEF;
    sample();
    check("rd_req_cycle", 32'(grant), 32'h0);
    tick();
    sample();
    check("rd_grant", 32'(grant), 32'h4);
    check("rd_data2", mgr_rData[2*DW +: DW], 32'hDEADBEEF);
    check("rd_data0", mgr_rData[0 +: DW], 32'h0);
    check("rd_busy", 32'(mgr_busy), 32'hB);
    check("rd_bus_addr", bus_addr, 32'h104);
    check("rd_bus_prot", 32'(bus_prot), 32'h2);
    tick();
    clear_all();
    sample();
    check("rd_idle", 32'(grant), 32'h0);
    check("rd_idle_data2", mgr_rData[2*DW +: DW], 32'h0);

    // Reset pulse restores last=3, then four continuous writers rotate 0,1,2,3,0.
    tick();
    nReset = 1'b0;
    for (int i = 0; i < NM; i++) set_mgr(i, 1'b1, 1'b0, 32'h2000 + i*16, 32'hA0 + i, 1'b0, 8'h0);
    sample();
    check("rr_reset_grant", 32'(grant), 32'h0);
    tick();
    nReset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      sample();
      check("rr_grant", 32'(grant), 32'h1 << (k % NM));
      check("rr_addr", bus_addr, 32'h2000 + (k % NM) * 16);
      check("rr_wdata", bus_wData, 32'hA0 + (k % NM));
      check("rr_wstrb", 32'(bus_wStrb), 32'hF);
      tick();
      sample();
      check("rr_gap", 32'(grant), 32'h0);
    end
    clear_all();

    // Burst of 4 beats from manager 1 with two wait cycles on the second beat; manager 0 waits.
    tick();
    set_mgr(0, 1'b0, 1'b1, 32'h3000, 32'h0, 1'b0, 8'h0);
    set_mgr(1, 1'b0, 1'b1, 32'h3100, 32'h0, 1'b1, 8'd3);
    bus_busy = 1'b0;
    sample();
    check("bu_req_cycle", 32'(grant), 32'h0);
    tick();
    sample();
    check("bu_beat0_grant", 32'(grant), 32'h2);
    check("bu_beat0_busy", 32'(mgr_busy), 32'hD);
    check("bu_len", 32'(bus_burstLen), 32'h3);
    check("bu_type", 32'(bus_burstType), 32'h1);
    tick();
    bus_busy = 1'b1;
    sample();
    check("bu_wait1_grant", 32'(grant), 32'h2);
    check("bu_wait1_busy", 32'(mgr_busy), 32'hF);
    tick();
    sample();
    check("bu_wait2_grant", 32'(grant), 32'h2);
    tick();
    bus_busy = 1'b0;
    sample();
    check("bu_beat1_grant", 32'(grant), 32'h2);
    tick();
    sample();
    check("bu_beat2_grant", 32'(grant), 32'h2);
    tick();
    sample();
    check("bu_beat3_grant", 32'(grant), 32'h2);
    tick();
    set_mgr(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0);
    sample();
    check("bu_dead_cycle", 32'(grant), 32'h0);
    tick();
    sample();
    check("bu_next_grant", 32'(grant), 32'h1);
    check("bu_next_addr", bus_addr, 32'h3000);
    tick();
    clear_all();
    sample();
    check("bu_done", 32'(grant), 32'h0);

    // Manager 3 burst of 8 aborted by an error on its second beat; manager 0 goes next.
    tick();
    set_mgr(3, 1'b1, 1'b0, 32'h4000, 32'hCAFE0000, 1'b1, 8'd7);
    set_mgr(0, 1'b1, 1'b0, 32'h4100, 32'h12345678, 1'b0, 8'h0);
    sample();
    check("er_req_cycle", 32'(grant), 32'h0);
    tick();
    sample();
    check("er_beat0_grant", 32'(grant), 32'h8);
    check("er_beat0_busy", 32'(mgr_busy), 32'h7);
    check("er_isburst", 32'(bus_isBurst), 32'h1);
    check("er_beat0_error", 32'(mgr_error), 32'h0);
    tick();
    bus_error = 1'b1;
    sample();
    check("er_beat1_grant", 32'(grant), 32'h8);
    check("er_beat1_error", 32'(mgr_error), 32'h8);
    tick();
    bus_error = 1'b0;
    sample();
    check("er_release", 32'(grant), 32'h0);
    check("er_release_error", 32'(mgr_error), 32'h0);
    tick();
    sample();
    check("er_next_grant", 32'(grant), 32'h1);
    check("er_next_addr", bus_addr, 32'h4100);

    // Asynchronous reset between edges while manager 0 owns the bus.
    bus_busy = 1'b1;
    #1;
    nReset = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_bus_wen", 32'(bus_wEn), 32'h0);
    check("ar_bus_addr", bus_addr, 32'h0);
    check("ar_busy", 32'(mgr_busy), 32'hF);
    tick();
    sample();
    check("ar_held_grant", 32'(grant), 32'h0);
    nReset = 1'b1;
    clear_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/generic_bus_arbiter.md
# generic_bus_arbiter

Round-robin arbiter that shares one GenericBus subordinate-side port among `NumMgrs` manager ports. It sits between several bus managers and a single GenericBus (typically feeding a GenericBusSubordinate decoder). It holds the grant for a whole transfer, including every beat of a burst, then re-arbitrates. Managers that are not granted see `busy` held high.

## Interface
- `DataWidth`, 32: data bus width in bits; a multiple of 8.
- `AddrWidth`, 32: address width in bits.
- `ProtWidth`, 4: protection field width in bits.
- `NumMgrs`, 4: number of manager ports; legal range 2..8. `IdxW = $clog2(NumMgrs)`.

Ports: clock `clk` and reset `nReset`. One clock; reset is asynchronous and active-low. Manager port `i` occupies slice `i` of each packed vector.
- `clk` in 1: clock.
- `nReset` in 1: asynchronous active-low reset.
- `mgr_wEn`, `mgr_rEn` in NumMgrs each: per-manager write/read request.
- `mgr_addr` in NumMgrs*AddrWidth: addresses.
- `mgr_wData` in NumMgrs*DataWidth: write data.
- `mgr_wStrb` in NumMgrs*DataWidth/8: byte strobes.
- `mgr_isBurst` in NumMgrs: burst qualifier.
- `mgr_burstType` in NumMgrs*2: burst type.
- `mgr_burstLen` in NumMgrs*8: beats minus one.
- `mgr_nonSec` in NumMgrs: non-secure attribute.
- `mgr_prot` in NumMgrs*ProtWidth: protection field.
- `mgr_rData` out NumMgrs*DataWidth: read data.
- `mgr_error` out NumMgrs: error response.
- `mgr_busy` out NumMgrs: stall.
- Shared bus outputs, same widths as one manager slice: `bus_wEn`, `bus_rEn`, `bus_addr`, `bus_wData`, `bus_wStrb`, `bus_isBurst`, `bus_burstType`, `bus_burstLen`, `bus_nonSec`, `bus_prot`.
- Shared bus inputs: `bus_rData` in DataWidth; `bus_error` in 1; `bus_busy` in 1.
- `grant` out NumMgrs: one-hot owner of the bus; all zeros when idle.

## Operation
- Request: `req[i] = mgr_wEn[i] | mgr_rEn[i]`.
- Beat completion: a beat completes in the cycle where `(bus_wEn | bus_rEn) & ~bus_busy`.
- State machine: IDLE and OWN.
- IDLE:
  - `grant` is zero and all bus outputs are 0.
  - If any `req` is high, the next edge registers the winner into `grant`, sets `owner` to that index, and moves to OWN.
  - Winner: first requester scanning `last+1, last+2, …` modulo `NumMgrs`.
- OWN:
  - All manager fields of `owner` pass combinationally to the bus.
  - `bus_rData`, `bus_error` and `bus_busy` pass combinationally back to `owner`.
- Beat counter `beats` (8 bits):
  - Cleared on entry to OWN.
  - Incremented on each completed beat while `bus_isBurst` is high.
- OWN returns to IDLE on the edge after any of:
  - a completed beat with `bus_isBurst` low;
  - a completed beat where `beats == bus_burstLen` (final beat, `burstLen+1` beats total);
  - a completed beat with `bus_error` high (a burst is aborted on error);
  - `req[owner]` deasserting (manager abort).
- On every transition to IDLE, `last <= owner`.
- Non-owners, in both states: `mgr_busy[i]=1`, `mgr_rData[i]=0`, `mgr_error[i]=0`.
- No manager is starved: after a release, every pending requester wins within `NumMgrs-1` arbitrations.

## Timing
- Reset values:
  - state IDLE; `grant`=0; `owner`=0; `last`=NumMgrs-1, so manager 0 wins first; `beats`=0.
  - All bus outputs 0; `mgr_busy` all 1; `mgr_rData` and `mgr_error` all 0.
- Arbitration latency: request seen in IDLE in cycle N, grant visible in cycle N+1. A single beat with zero wait states completes in N+1.
- Release: the edge after the completing beat returns to IDLE. One dead bus cycle follows, then the next grant. Back-to-back single transfers from different managers therefore complete every 2 cycles.
- Wait states: while `bus_busy` is high the grant is held indefinitely, with no timeout.
- Simultaneous error and final beat: release once; `last` updates normally.
- Requests arriving in the release cycle: ignored until IDLE.
- Reset asserted mid-burst: all registers return to reset values immediately (asynchronously); the in-flight transfer is dropped.

## Test plan
- Reset: hold `nReset`=0 with all `req` high, then release → cycle 1 after release `grant`=4'b0001; `mgr_busy`=4'b1110.
- Single read: mgr2 `rEn`=1, `addr`=32'h104; sub returns `bus_busy`=0, `bus_rData`=32'hDEADBEEF → `mgr_rData[2]`=32'hDEADBEEF and `mgr_busy[2]`=0 in the grant cycle; IDLE the next cycle.
- Round-robin: all four managers hold single writes continuously; sub never busy → grants in order 0,1,2,3,0, one every 2 cycles.
- Burst hold: mgr1 `isBurst`=1, `burstLen`=3; mgr0 requesting throughout; sub inserts 2 wait cycles on beat 2 → `grant` stays 4'b0010 through 4 completed beats (6 cycles); mgr0 is granted 2 cycles after the last beat.
- Error abort: mgr3 burst with `burstLen`=7; `bus_error`=1 on beat 2 → release after beat 2 and `mgr_error[3]`=1 in that cycle; next requester granted.
- Async reset mid-burst: drop `nReset` between edges while mgr0 is granted → `grant`=0 and bus outputs 0 immediately, without waiting for a clock edge.
